// File: rtl/uart_tx_word_fifo.sv
// Word FIFO between execute and the byte-wide UART sender; each 32-bit word leaves as 4 bytes.
// Optional sticky overflow flag when UART_TX_WORD_FIFO_OVERFLOW_EN is defined.
module uart_tx_word_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [31:0]           wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            tx_data,
    output logic                  tx_enable,
    input  logic                  tx_ready,
    output logic                  busy
`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
    ,
    output logic                  overflow,
    input  logic                  overflow_clr
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [31:0]           shreg;
    logic [1:0]            byte_cnt;
    logic [7:0]            tx_data_q;
    logic [7:0]            cur_byte;
    logic [31:0]           shifted;
    logic                  push, pop;

    assign full  = (count == FULL_LEVEL);
    assign empty = (count == '0);
    assign level = count;
    assign busy  = (state_q != IDLE);
    assign push  = wr_en && !full;
    assign pop   = (state_q == LOAD);

    assign cur_byte = MSB_FIRST ? shreg[31:24] : shreg[7:0];
    assign shifted  = MSB_FIRST ? {shreg[23:0], 8'h00} : {8'h00, shreg[31:8]};

    // Only the byte under transmission is exposed in SEND; elsewhere the last sent byte is held.
    assign tx_data = (state_q == SEND) ? cur_byte : tx_data_q;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The WAIT_BUSY/WAIT_DONE pair demands a high-low-high on tx_ready before the next byte.
    always_comb begin
        state_d   = state_q;
        tx_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    tx_enable = 1'b1;
                    state_d   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = (byte_cnt == 2'd3) ? IDLE : SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            shreg     <= '0;
            byte_cnt  <= '0;
            tx_data_q <= '0;
        end else begin
            if (state_q == LOAD) begin
                shreg    <= mem[rd_ptr];
                byte_cnt <= '0;
            end else if (state_q == WAIT_DONE && tx_ready && byte_cnt != 2'd3) begin
                shreg    <= shifted;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (tx_enable) begin
                tx_data_q <= cur_byte;
            end
        end
    end

`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
    // A dropped push outranks a clear arriving in the same cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// Scoreboard bench for uart_tx_word_fifo: MSB-first instance plus an LSB-first instance,
// each with a modelled UART sender that drops tx_ready for 3 cycles per accepted byte.
module tb_uart_tx_word_fifo;

    localparam int MODE_AUTO       = 0;
    localparam int MODE_STUCK_LOW  = 1;
    localparam int MODE_STUCK_HIGH = 2;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        full, empty, busy, tx_enable;
    logic [3:0]  level;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;

    logic [31:0] l_wr_data;
    logic        l_wr_en;
    logic        l_full, l_empty, l_busy, l_tx_enable;
    logic [3:0]  l_level;
    logic [7:0]  l_tx_data;
    logic        l_tx_ready = 1'b1;

`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
    logic        overflow, l_overflow;
    logic        overflow_clr;
    logic        l_overflow_clr = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          en_count = 0;
    int          l_en_count = 0;
    int          sender_mode = MODE_AUTO;
    logic [7:0]  exp_q[$];
    logic [7:0]  l_exp_q[$];

    always #5 CLK = ~CLK;

    uart_tx_word_fifo #(.DEPTH_LOG2(3), .MSB_FIRST(1'b1)) dut (
        .CLK(CLK), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .level(level), .tx_data(tx_data),
        .tx_enable(tx_enable), .tx_ready(tx_ready), .busy(busy)
`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
        , .overflow(overflow), .overflow_clr(overflow_clr)
`endif
    );

    uart_tx_word_fifo #(.DEPTH_LOG2(3), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(CLK), .reset(reset), .wr_data(l_wr_data), .wr_en(l_wr_en),
        .full(l_full), .empty(l_empty), .level(l_level), .tx_data(l_tx_data),
        .tx_enable(l_tx_enable), .tx_ready(l_tx_ready), .busy(l_busy)
`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
        , .overflow(l_overflow), .overflow_clr(l_overflow_clr)
`endif
    );

    // Sender models: a seen tx_enable makes tx_ready go low for the next 3 cycles.
    initial begin
        logic saw;
        int   low_cnt;
        low_cnt = 0;
        forever begin
            @(negedge CLK);
            saw = tx_enable;
            @(posedge CLK);
            #1;
            if (saw && sender_mode == MODE_AUTO) low_cnt = 3;
            if (sender_mode == MODE_STUCK_LOW) tx_ready = 1'b0;
            else if (sender_mode == MODE_STUCK_HIGH) tx_ready = 1'b1;
            else if (low_cnt > 0) begin
                tx_ready = 1'b0;
                low_cnt--;
            end else tx_ready = 1'b1;
        end
    end

    initial begin
        logic saw;
        int   low_cnt;
        low_cnt = 0;
        forever begin
            @(negedge CLK);
            saw = l_tx_enable;
            @(posedge CLK);
            #1;
            if (saw) low_cnt = 3;
            if (low_cnt > 0) begin
                l_tx_ready = 1'b0;
                low_cnt--;
            end else l_tx_ready = 1'b1;
        end
    end

    // Monitors pop the scoreboard whenever a byte is offered to the sender.
    initial begin
        logic       prev_en;
        logic [7:0] e;
        prev_en = 1'b0;
        forever begin
            @(negedge CLK);
            if (tx_enable) begin
                en_count++;
                checks++;
                if (prev_en) begin
                    errors++;
                    $display("[TB] FAIL tx_enable_pulse: got 2 consecutive cycles expected 1");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got %02h expected no tx_enable", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("[TB] FAIL byte: got %02h expected %02h", tx_data, e);
                    end
                end
            end
            prev_en = tx_enable;
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            if (l_tx_enable) begin
                l_en_count++;
                checks++;
                if (l_exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL lsb_unexpected_byte: got %02h expected no tx_enable", l_tx_data);
                end else begin
                    e = l_exp_q.pop_front();
                    if (l_tx_data !== e) begin
                        errors++;
                        $display("[TB] FAIL lsb_byte: got %02h expected %02h", l_tx_data, e);
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic expect_word(input logic [31:0] w, input int nbytes);
        logic [7:0] b [4];
        b[0] = w[31:24];
        b[1] = w[23:16];
        b[2] = w[15:8];
        b[3] = w[7:0];
        for (int k = 0; k < nbytes; k++) exp_q.push_back(b[k]);
    endtask

    // Push one word and queue the first nbytes it is expected to produce (MSB first).
    task automatic apply_stimulus(input logic [31:0] w, input int nbytes);
        @(posedge CLK);
        #1;
        wr_data = w;
        wr_en   = 1'b1;
        expect_word(w, nbytes);
        @(posedge CLK);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n;
        n = 0;
        while ((busy || !empty || exp_q.size() != 0) && n < max_cycles) begin
            @(negedge CLK);
            n++;
        end
        check_output({name, "_drained"}, {31'd0, (busy || !empty || exp_q.size() != 0)}, 32'd0);
    endtask

    function automatic logic [31:0] fill_word(input logic [7:0] i);
        return {i, 8'h20 + i, 8'h40 + i, 8'h60 + i};
    endfunction

    initial begin
        int en0;
        int n;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        l_wr_en   = 1'b0;
        l_wr_data = '0;
`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
        overflow_clr = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        check_output("reset_full", full, 0);
        check_output("reset_empty", empty, 1);
        check_output("reset_level", level, 0);
        check_output("reset_tx_data", tx_data, 0);
        check_output("reset_tx_enable", tx_enable, 0);
        check_output("reset_busy", busy, 0);
`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
        check_output("reset_overflow", overflow, 0);
`endif
        reset = 1'b0;

        // Single word, MSB first, first tx_enable two cycles after the push edge
        apply_stimulus(32'h12345678, 4);
        @(negedge CLK);
        check_output("lat_cycN_level", level, 1);
        check_output("lat_cycN_busy", busy, 0);
        @(negedge CLK);
        check_output("lat_load_busy", busy, 1);
        check_output("lat_load_tx_enable", tx_enable, 0);
        @(negedge CLK);
        check_output("lat_first_tx_enable", tx_enable, 1);
        check_output("lat_first_tx_data", tx_data, 32'h12);
        check_output("lat_popped_level", level, 0);
        @(negedge CLK);
        check_output("hold_tx_enable", tx_enable, 0);
        check_output("hold_tx_data", tx_data, 32'h12);
        wait_idle(200, "single_word");
        check_output("single_word_busy", busy, 0);

        // LSB-first instance
        @(posedge CLK);
        #1;
        l_wr_data = 32'hA1B2C3D4;
        l_wr_en   = 1'b1;
        l_exp_q.push_back(8'hD4);
        l_exp_q.push_back(8'hC3);
        l_exp_q.push_back(8'hB2);
        l_exp_q.push_back(8'hA1);
        @(posedge CLK);
        #1;
        l_wr_en = 1'b0;
        n = 0;
        while ((l_busy || l_exp_q.size() != 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_output("lsb_drained", l_exp_q.size(), 0);
        check_output("lsb_byte_count", l_en_count, 4);
        check_output("lsb_busy", l_busy, 0);

        // Fill with the sender stuck busy
        @(posedge CLK);
        #1;
        sender_mode = MODE_STUCK_LOW;
        repeat (2) @(posedge CLK);
        #1;
        en0 = en_count;
        for (int i = 0; i < 10; i++) begin
            wr_data = fill_word(i[7:0]);
            wr_en   = 1'b1;
            if (i < 9) expect_word(wr_data, 4);
            @(posedge CLK);
            #1;
            if (i == 7) begin
                check_output("fill8_level", level, 7);
                check_output("fill8_full", full, 0);
            end
            if (i == 8) begin
                check_output("fill9_level", level, 8);
                check_output("fill9_full", full, 1);
`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
                check_output("fill9_overflow", overflow, 0);
`endif
            end
            if (i == 9) begin
                check_output("fill10_level", level, 8);
                check_output("fill10_full", full, 1);
`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
                check_output("fill10_overflow", overflow, 1);
`endif
            end
        end
        wr_en = 1'b0;
`ifdef UART_TX_WORD_FIFO_OVERFLOW_EN
        overflow_clr = 1'b1;
        @(posedge CLK);
        #1;
        overflow_clr = 1'b0;
        check_output("overflow_cleared", overflow, 0);
`endif
        check_output("fill_no_tx_while_stuck", en_count - en0, 0);
        sender_mode = MODE_AUTO;
        wait_idle(1500, "fill_release");
        check_output("fill_byte_count", en_count - en0, 36);
        check_output("fill_level", level, 0);
        check_output("fill_empty", empty, 1);

        // Sender never drops tx_ready: only one byte may be issued
        @(posedge CLK);
        #1;
        sender_mode = MODE_STUCK_HIGH;
        repeat (2) @(posedge CLK);
        en0 = en_count;
        apply_stimulus(32'hDEADBEEF, 1);
        repeat (30) @(negedge CLK);
        check_output("guard_single_enable", en_count - en0, 1);
        check_output("guard_busy", busy, 1);
        check_output("guard_scoreboard", exp_q.size(), 0);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        sender_mode = MODE_AUTO;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge CLK);

        // Reset after the 2nd byte with two more words queued
        en0 = en_count;
        apply_stimulus(32'hCAFEBABE, 2);
        apply_stimulus(32'h11223344, 0);
        apply_stimulus(32'h55667788, 0);
        n = 0;
        while (en_count - en0 < 2 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_output("midword_two_bytes", en_count - en0, 2);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check_output("midword_empty", empty, 1);
        check_output("midword_level", level, 0);
        check_output("midword_busy", busy, 0);
        reset = 1'b0;
        en0 = en_count;
        repeat (20) @(negedge CLK);
        check_output("midword_silent", en_count - en0, 0);

        // Pointer wrap: 20 words trickled in while draining
        en0 = en_count;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus({i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC0 + i[7:0]}, 4);
            repeat (30) @(posedge CLK);
        end
        wait_idle(500, "wrap");
        check_output("wrap_byte_count", en_count - en0, 80);
        check_output("wrap_level", level, 0);
        check_output("wrap_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
